// File: rtl/axi_master_request_scheduler.sv
// AXI4 master request scheduler: issues AW/W/AR toward the slave from the channel FIFOs,
// queues AW burst lengths so address can run ahead of data, and caps outstanding transactions.
module axi_master_request_scheduler #(
    parameter int                          AxLEN_FIELD_WIDTH   = 8,
    parameter int                          Ax_SIZE_WIDTH       = 3,
    parameter int                          Ax_BURST_WIDTH      = 2,
    parameter int                          Ax_PROTECTION_WIDTH = 2,
    parameter logic [Ax_SIZE_WIDTH-1:0]    AX_SIZE_VAL         = 3'b111,
    parameter logic [Ax_BURST_WIDTH-1:0]   AX_BURST_VAL        = 2'b01,
    parameter int                          LEN_Q_DEPTH         = 4,
    parameter int                          MAX_WR_OUTSTANDING  = 4,
    parameter int                          MAX_RD_OUTSTANDING  = 4,
    parameter int                          OW = $clog2(((MAX_WR_OUTSTANDING > MAX_RD_OUTSTANDING) ?
                                                        MAX_WR_OUTSTANDING : MAX_RD_OUTSTANDING) + 1)
) (
    input  logic                           i_clk,
    input  logic                           i_n_rst,
    input  logic [AxLEN_FIELD_WIDTH-1:0]   i_AWLEN,
    input  logic                           i_AWVALID_fifo,
    output logic                           o_aw_ch_fifo_read_inc,
    output logic [Ax_SIZE_WIDTH-1:0]       o_s_AWSIZE,
    output logic [Ax_BURST_WIDTH-1:0]      o_s_AWBURST,
    output logic [Ax_PROTECTION_WIDTH-1:0] o_s_AWPROT,
    output logic                           o_s_AWVALID,
    input  logic                           i_s_AWREADY,
    input  logic                           i_WVALID_fifo,
    output logic                           o_w_ch_fifo_read_inc,
    output logic                           o_s_WVALID,
    output logic                           o_s_WLAST,
    input  logic                           i_s_WREADY,
    input  logic                           i_ARVALID_fifo,
    output logic                           o_ar_ch_fifo_read_inc,
    output logic [Ax_SIZE_WIDTH-1:0]       o_s_ARSIZE,
    output logic [Ax_BURST_WIDTH-1:0]      o_s_ARBURST,
    output logic [Ax_PROTECTION_WIDTH-1:0] o_s_ARPROT,
    output logic                           o_s_ARVALID,
    input  logic                           i_s_ARREADY,
    input  logic                           i_wr_done,
    input  logic                           i_rd_done,
    output logic [OW-1:0]                  o_wr_outstanding,
    output logic [OW-1:0]                  o_rd_outstanding,
    output logic                           o_idle
);

    localparam int PW = (LEN_Q_DEPTH > 1) ? $clog2(LEN_Q_DEPTH) : 1;
    localparam int CW = $clog2(LEN_Q_DEPTH + 1);
    localparam logic [OW-1:0] MAX_WR_C = OW'(MAX_WR_OUTSTANDING);
    localparam logic [OW-1:0] MAX_RD_C = OW'(MAX_RD_OUTSTANDING);
    localparam logic [CW-1:0] DEPTH_C  = CW'(LEN_Q_DEPTH);

    typedef enum logic {W_IDLE, W_BURST} w_state_t;

    w_state_t                         w_state_q;
    logic [AxLEN_FIELD_WIDTH-1:0]     beat_cnt_q;
    logic [AxLEN_FIELD_WIDTH-1:0]     lenq_q [LEN_Q_DEPTH];
    logic [PW-1:0]                    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                    cnt_q, cnt_d;
    logic [OW-1:0]                    wr_out_q, wr_out_d;
    logic [OW-1:0]                    rd_out_q, rd_out_d;
    logic                             run_q;

    logic                             lenq_full, lenq_push, lenq_pop, lenq_more;
    logic                             aw_hs, w_hs, ar_hs, wr_dec, rd_dec;
    logic [PW-1:0]                    rd_ptr_inc;
    logic [AxLEN_FIELD_WIDTH-1:0]     head_after_pop;

    // run_q keeps every VALID low while reset is held and for the first edge after release.
    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) run_q <= 1'b0;
        else          run_q <= 1'b1;
    end

    assign lenq_full   = (cnt_q == DEPTH_C);
    assign o_s_AWVALID = run_q & i_AWVALID_fifo & ~lenq_full & (wr_out_q < MAX_WR_C);
    assign o_s_ARVALID = run_q & i_ARVALID_fifo & (rd_out_q < MAX_RD_C);
    assign o_s_WVALID  = (w_state_q == W_BURST) & i_WVALID_fifo;
    assign o_s_WLAST   = (w_state_q == W_BURST) & (beat_cnt_q == '0);

    assign aw_hs = o_s_AWVALID & i_s_AWREADY;
    assign w_hs  = o_s_WVALID  & i_s_WREADY;
    assign ar_hs = o_s_ARVALID & i_s_ARREADY;

    assign o_aw_ch_fifo_read_inc = aw_hs;
    assign o_w_ch_fifo_read_inc  = w_hs;
    assign o_ar_ch_fifo_read_inc = ar_hs;

    assign o_s_AWSIZE  = AX_SIZE_VAL;
    assign o_s_AWBURST = AX_BURST_VAL;
    assign o_s_AWPROT  = '0;
    assign o_s_ARSIZE  = AX_SIZE_VAL;
    assign o_s_ARBURST = AX_BURST_VAL;
    assign o_s_ARPROT  = '0;

    assign lenq_push  = aw_hs;
    assign lenq_pop   = w_hs & o_s_WLAST;
    assign rd_ptr_inc = rd_ptr_q + PW'(1);
    // A same-cycle push into a one-entry queue becomes the next head directly.
    assign head_after_pop = (cnt_q == CW'(1)) ? i_AWLEN : lenq_q[rd_ptr_inc];
    assign lenq_more      = (cnt_q != CW'(1)) | lenq_push;

    assign wr_dec = i_wr_done & (wr_out_q != '0);
    assign rd_dec = i_rd_done & (rd_out_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        wr_out_d = wr_out_q;
        rd_out_d = rd_out_q;
        if (lenq_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (lenq_pop)  rd_ptr_d = rd_ptr_inc;
        case ({lenq_push, lenq_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        case ({aw_hs, wr_dec})
            2'b10:   wr_out_d = wr_out_q + OW'(1);
            2'b01:   wr_out_d = wr_out_q - OW'(1);
            default: wr_out_d = wr_out_q;
        endcase
        case ({ar_hs, rd_dec})
            2'b10:   rd_out_d = rd_out_q + OW'(1);
            2'b01:   rd_out_d = rd_out_q - OW'(1);
            default: rd_out_d = rd_out_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            wr_out_q <= '0;
            rd_out_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            wr_out_q <= wr_out_d;
            rd_out_q <= rd_out_d;
        end
    end

    // Entry storage needs no reset: occupancy is tracked by cnt_q alone.
    always_ff @(posedge i_clk) begin
        if (lenq_push) lenq_q[wr_ptr_q] <= i_AWLEN;
    end

    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            w_state_q  <= W_IDLE;
            beat_cnt_q <= '0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (cnt_q != '0) begin
                        beat_cnt_q <= lenq_q[rd_ptr_q];
                        w_state_q  <= W_BURST;
                    end
                end
                W_BURST: begin
                    if (w_hs) begin
                        if (beat_cnt_q != '0) begin
                            beat_cnt_q <= beat_cnt_q - AxLEN_FIELD_WIDTH'(1);
                        end else if (lenq_more) begin
                            beat_cnt_q <= head_after_pop;
                        end else begin
                            w_state_q <= W_IDLE;
                        end
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    assign o_wr_outstanding = wr_out_q;
    assign o_rd_outstanding = rd_out_q;
    assign o_idle = (wr_out_q == '0) & (rd_out_q == '0) & (cnt_q == '0) & (w_state_q == W_IDLE);

endmodule

// File: tb/tb_axi_master_request_scheduler.sv
// Directed bench for axi_master_request_scheduler: a per-cycle vector table for the
// basic write/read flows plus hand sequences for stall, outstanding limits and reset.
module tb_axi_master_request_scheduler;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [7:0] awlen = '0;
    logic       awvalid_fifo = 1'b0, awready = 1'b0, wvalid_fifo = 1'b0, wready = 1'b0;
    logic       arvalid_fifo = 1'b0, arready = 1'b0, wr_done = 1'b0, rd_done = 1'b0;
    logic       aw_pop, w_pop, ar_pop, awvalid, wvalid, wlast, arvalid, idle;
    logic [2:0] awsize, arsize;
    logic [1:0] awburst, arburst, awprot, arprot;
    logic [2:0] wr_out, rd_out;

    int n_chk  = 0;
    int n_pass = 0;

    axi_master_request_scheduler dut (
        .i_clk                 (clk),
        .i_n_rst               (n_rst),
        .i_AWLEN               (awlen),
        .i_AWVALID_fifo        (awvalid_fifo),
        .o_aw_ch_fifo_read_inc (aw_pop),
        .o_s_AWSIZE            (awsize),
        .o_s_AWBURST           (awburst),
        .o_s_AWPROT            (awprot),
        .o_s_AWVALID           (awvalid),
        .i_s_AWREADY           (awready),
        .i_WVALID_fifo         (wvalid_fifo),
        .o_w_ch_fifo_read_inc  (w_pop),
        .o_s_WVALID            (wvalid),
        .o_s_WLAST             (wlast),
        .i_s_WREADY            (wready),
        .i_ARVALID_fifo        (arvalid_fifo),
        .o_ar_ch_fifo_read_inc (ar_pop),
        .o_s_ARSIZE            (arsize),
        .o_s_ARBURST           (arburst),
        .o_s_ARPROT            (arprot),
        .o_s_ARVALID           (arvalid),
        .i_s_ARREADY           (arready),
        .i_wr_done             (wr_done),
        .i_rd_done             (rd_done),
        .o_wr_outstanding      (wr_out),
        .o_rd_outstanding      (rd_out),
        .o_idle                (idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          awf;
        int          len;
        bit          awr, wf, wr, arf, arr, wd, rd;
        logic [13:0] exp;
    } vec_t;

    vec_t tbl [22];

    // Output bundle: {AWVALID, AWpop, WVALID, WLAST, Wpop, ARVALID, ARpop, idle, wr_out, rd_out}
    function automatic logic [13:0] ex(input bit awv, awp, wv, wl, wp, arv, arp, idl,
                                       input int wro, rdo);
        return {awv, awp, wv, wl, wp, arv, arp, idl, 3'(wro), 3'(rdo)};
    endfunction

    function automatic logic [13:0] obs();
        return {awvalid, aw_pop, wvalid, wlast, w_pop, arvalid, ar_pop, idle, wr_out, rd_out};
    endfunction

    task automatic chk(input string name, input logic [13:0] exp);
        logic [13:0] got;
        got = obs();
        n_chk++;
        if (got === exp) begin
            n_pass++;
            $display("check %s obs=%b ok", name, got);
        end else begin
            $display("FAIL %s: got %b want %b", name, got, exp);
        end
    endtask

    // Apply inputs just after the falling edge and compare before the next rising edge.
    task automatic step(input string name, input bit awf, input int len, input bit awr, wf, wr,
                        arf, arr, wd, rd, input logic [13:0] exp);
        @(negedge clk);
        awvalid_fifo = awf; awlen = 8'(len); awready = awr; wvalid_fifo = wf; wready = wr;
        arvalid_fifo = arf; arready = arr; wr_done = wd; rd_done = rd;
        #1;
        chk(name, exp);
    endtask

    initial begin
        // Single AWLEN=3 burst, one AR, then done pulses.
        tbl[0]  = '{1, 3, 1, 1, 1, 0, 1, 0, 0, ex(1,1,0,0,0,0,0,1,0,0)};
        tbl[1]  = '{0, 0, 1, 1, 1, 0, 1, 0, 0, ex(0,0,0,0,0,0,0,0,1,0)};
        tbl[2]  = '{0, 0, 1, 1, 1, 0, 1, 0, 0, ex(0,0,1,0,1,0,0,0,1,0)};
        tbl[3]  = '{0, 0, 1, 1, 1, 0, 1, 0, 0, ex(0,0,1,0,1,0,0,0,1,0)};
        tbl[4]  = '{0, 0, 1, 1, 1, 0, 1, 0, 0, ex(0,0,1,0,1,0,0,0,1,0)};
        tbl[5]  = '{0, 0, 1, 1, 1, 0, 1, 0, 0, ex(0,0,1,1,1,0,0,0,1,0)};
        tbl[6]  = '{0, 0, 1, 1, 1, 0, 1, 0, 0, ex(0,0,0,0,0,0,0,0,1,0)};
        tbl[7]  = '{0, 0, 1, 1, 1, 1, 1, 1, 0, ex(0,0,0,0,0,1,1,0,1,0)};
        tbl[8]  = '{0, 0, 1, 1, 1, 0, 1, 0, 1, ex(0,0,0,0,0,0,0,0,0,1)};
        tbl[9]  = '{0, 0, 1, 1, 1, 0, 1, 0, 0, ex(0,0,0,0,0,0,0,1,0,0)};
        // Three AWs (LEN 1,0,2) back to back, then six gap-free beats.
        tbl[10] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, ex(1,1,0,0,0,0,0,1,0,0)};
        tbl[11] = '{1, 0, 1, 1, 1, 0, 0, 0, 0, ex(1,1,0,0,0,0,0,0,1,0)};
        tbl[12] = '{1, 2, 1, 1, 1, 0, 0, 0, 0, ex(1,1,1,0,1,0,0,0,2,0)};
        tbl[13] = '{0, 0, 1, 1, 1, 0, 0, 0, 0, ex(0,0,1,1,1,0,0,0,3,0)};
        tbl[14] = '{0, 0, 1, 1, 1, 0, 0, 0, 0, ex(0,0,1,1,1,0,0,0,3,0)};
        tbl[15] = '{0, 0, 1, 1, 1, 0, 0, 0, 0, ex(0,0,1,0,1,0,0,0,3,0)};
        tbl[16] = '{0, 0, 1, 1, 1, 0, 0, 0, 0, ex(0,0,1,0,1,0,0,0,3,0)};
        tbl[17] = '{0, 0, 1, 1, 1, 0, 0, 0, 0, ex(0,0,1,1,1,0,0,0,3,0)};
        tbl[18] = '{0, 0, 1, 1, 1, 0, 0, 1, 0, ex(0,0,0,0,0,0,0,0,3,0)};
        tbl[19] = '{0, 0, 1, 1, 1, 0, 0, 1, 0, ex(0,0,0,0,0,0,0,0,2,0)};
        tbl[20] = '{0, 0, 1, 1, 1, 0, 0, 1, 0, ex(0,0,0,0,0,0,0,0,1,0)};
        tbl[21] = '{0, 0, 1, 1, 1, 0, 0, 0, 0, ex(0,0,0,0,0,0,0,1,0,0)};

        // Reset: VALIDs stay low even with requests pending in the FIFOs.
        awvalid_fifo = 1'b1; arvalid_fifo = 1'b1; wvalid_fifo = 1'b1;
        awready = 1'b1; arready = 1'b1; wready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_state", ex(0,0,0,0,0,0,0,1,0,0));
        n_chk++;
        if ({awsize, awburst, awprot, arsize, arburst, arprot} === 14'b111_01_00_111_01_00) begin
            n_pass++;
            $display("check constants ok");
        end else begin
            $display("FAIL constants: got %b want %b",
                     {awsize, awburst, awprot, arsize, arburst, arprot}, 14'b111_01_00_111_01_00);
        end
        @(negedge clk);
        n_rst = 1'b1;
        awvalid_fifo = 1'b0; arvalid_fifo = 1'b0;
        step("post_reset", 0, 0, 1, 1, 1, 0, 1, 0, 0, ex(0,0,0,0,0,0,0,1,0,0));

        for (int i = 0; i < 22; i++) begin
            step($sformatf("vec%0d", i), tbl[i].awf, tbl[i].len, tbl[i].awr, tbl[i].wf,
                 tbl[i].wr, tbl[i].arf, tbl[i].arr, tbl[i].wd, tbl[i].rd, tbl[i].exp);
        end

        // WREADY stalls the second beat of an AWLEN=3 burst for three cycles.
        step("stall_aw",  1, 3, 1, 1, 1, 0, 0, 0, 0, ex(1,1,0,0,0,0,0,1,0,0));
        step("stall_ld",  0, 0, 1, 1, 1, 0, 0, 0, 0, ex(0,0,0,0,0,0,0,0,1,0));
        step("stall_b1",  0, 0, 1, 1, 1, 0, 0, 0, 0, ex(0,0,1,0,1,0,0,0,1,0));
        for (int i = 0; i < 3; i++)
            step($sformatf("stall_hold%0d", i), 0, 0, 1, 1, 0, 0, 0, 0, 0, ex(0,0,1,0,0,0,0,0,1,0));
        step("stall_b2",  0, 0, 1, 1, 1, 0, 0, 0, 0, ex(0,0,1,0,1,0,0,0,1,0));
        step("stall_b3",  0, 0, 1, 1, 1, 0, 0, 0, 0, ex(0,0,1,0,1,0,0,0,1,0));
        step("stall_b4",  0, 0, 1, 1, 1, 0, 0, 0, 0, ex(0,0,1,1,1,0,0,0,1,0));
        step("stall_end", 0, 0, 1, 1, 1, 0, 0, 1, 0, ex(0,0,0,0,0,0,0,0,1,0));
        step("stall_idl", 0, 0, 1, 1, 1, 0, 0, 0, 0, ex(0,0,0,0,0,0,0,1,0,0));

        // Write outstanding limit: four AWLEN=0 bursts, fifth held until a done pulse.
        step("wmax_aw0", 1, 0, 1, 1, 1, 0, 0, 0, 0, ex(1,1,0,0,0,0,0,1,0,0));
        step("wmax_aw1", 1, 0, 1, 1, 1, 0, 0, 0, 0, ex(1,1,0,0,0,0,0,0,1,0));
        step("wmax_aw2", 1, 0, 1, 1, 1, 0, 0, 0, 0, ex(1,1,1,1,1,0,0,0,2,0));
        step("wmax_aw3", 1, 0, 1, 1, 1, 0, 0, 0, 0, ex(1,1,1,1,1,0,0,0,3,0));
        step("wmax_blk", 1, 0, 1, 1, 1, 0, 0, 0, 0, ex(0,0,1,1,1,0,0,0,4,0));
        step("wmax_done",1, 0, 1, 1, 1, 0, 0, 1, 0, ex(0,0,1,1,1,0,0,0,4,0));
        step("wmax_aw4", 1, 0, 1, 1, 1, 0, 0, 0, 0, ex(1,1,0,0,0,0,0,0,3,0));
        step("wmax_blk2",1, 0, 1, 1, 1, 0, 0, 0, 0, ex(0,0,0,0,0,0,0,0,4,0));
        step("wmax_beat",0, 0, 1, 1, 1, 0, 0, 0, 0, ex(0,0,1,1,1,0,0,0,4,0));
        for (int i = 0; i < 4; i++)
            step($sformatf("wmax_drain%0d", i), 0, 0, 1, 1, 1, 0, 0, 1, 0,
                 ex(0,0,0,0,0,0,0,0,4-i,0));
        step("wmax_idle", 0, 0, 1, 1, 1, 0, 0, 0, 0, ex(0,0,0,0,0,0,0,1,0,0));

        // Read outstanding limit, simultaneous AR handshake and done, done at zero.
        for (int i = 0; i < 4; i++)
            step($sformatf("rd_ar%0d", i), 0, 0, 0, 0, 0, 1, 1, 0, 0,
                 ex(0,0,0,0,0,1,1,(i == 0),0,i));
        step("rd_blk",   0, 0, 0, 0, 0, 1, 1, 0, 0, ex(0,0,0,0,0,0,0,0,0,4));
        step("rd_done4", 0, 0, 0, 0, 0, 1, 1, 0, 1, ex(0,0,0,0,0,0,0,0,0,4));
        step("rd_hs_dn", 0, 0, 0, 0, 0, 1, 1, 0, 1, ex(0,0,0,0,0,1,1,0,0,3));
        for (int i = 0; i < 3; i++)
            step($sformatf("rd_dn%0d", i), 0, 0, 0, 0, 0, 0, 1, 0, 1, ex(0,0,0,0,0,0,0,0,0,3-i));
        step("rd_dn_zero", 0, 0, 0, 0, 0, 0, 1, 0, 1, ex(0,0,0,0,0,0,0,1,0,0));
        step("rd_zero",    0, 0, 0, 0, 0, 0, 1, 0, 0, ex(0,0,0,0,0,0,0,1,0,0));

        // Reset asserted in the middle of a burst, then a fresh single-beat burst.
        step("rst_aw", 1, 3, 1, 1, 1, 0, 0, 0, 0, ex(1,1,0,0,0,0,0,1,0,0));
        step("rst_ld", 0, 0, 1, 1, 1, 0, 0, 0, 0, ex(0,0,0,0,0,0,0,0,1,0));
        step("rst_b1", 1, 5, 1, 1, 1, 1, 1, 0, 0, ex(1,1,1,0,1,1,1,0,1,0));
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        chk("rst_mid", ex(0,0,0,0,0,0,0,1,0,0));
        @(negedge clk);
        #1;
        chk("rst_hold", ex(0,0,0,0,0,0,0,1,0,0));
        @(negedge clk);
        n_rst = 1'b1;
        awvalid_fifo = 1'b0; arvalid_fifo = 1'b0;
        step("rst_rel",  0, 0, 1, 1, 1, 0, 0, 0, 0, ex(0,0,0,0,0,0,0,1,0,0));
        step("rst_aw0",  1, 0, 1, 1, 1, 0, 0, 0, 0, ex(1,1,0,0,0,0,0,1,0,0));
        step("rst_ld0",  0, 0, 1, 1, 1, 0, 0, 0, 0, ex(0,0,0,0,0,0,0,0,1,0));
        step("rst_beat", 0, 0, 1, 1, 1, 0, 0, 0, 0, ex(0,0,1,1,1,0,0,0,1,0));
        step("rst_done", 0, 0, 1, 1, 1, 0, 0, 1, 0, ex(0,0,0,0,0,0,0,0,1,0));
        step("rst_idle", 0, 0, 1, 1, 1, 0, 0, 0, 0, ex(0,0,0,0,0,0,0,1,0,0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
